// File: rtl/axi_req_cut_if.sv
// Ariane-style AXI request/response structs and the bundle interface that
// carries them between the core side and the AXI bridge side.
package ariane_axi;
    localparam int IdW   = 4;
    localparam int AddrW = 64;
    localparam int DataW = 64;
    localparam int UserW = 1;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [5:0]       atop;
        logic [UserW-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [UserW-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
        logic [UserW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [1:0]       resp;
        logic [UserW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic [UserW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

interface axi_req_cut_if;
    import ariane_axi::*;
    req_t  req;
    resp_t resp;
    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/axi_req_cut.sv
// Register slice on Ariane AXI struct channels, 2-entry skid buffer per channel.
// Optional AW/AR handshake counters under AXI_REQ_CUT_PERF_EN.
module axi_req_cut_slice #(
    parameter bit  CUT = 1'b1,
    parameter type T   = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    if (CUT) begin : g_cut
        state_t state, state_nxt;
        T       main_q, skid_q;
        logic   push, pop, ld_main, ld_skid, sel_skid;

        assign in_ready  = (state != FULL);
        assign out_valid = (state != EMPTY);
        assign out_data  = main_q;
        assign push      = in_valid & in_ready;
        assign pop       = out_valid & out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state <= EMPTY;
            else        state <= state_nxt;
        end

        always_comb begin
            state_nxt = state;
            ld_main   = 1'b0;
            ld_skid   = 1'b0;
            sel_skid  = 1'b0;
            case (state)
                EMPTY: if (push) begin
                    state_nxt = ONE;
                    ld_main   = 1'b1;
                end
                ONE: if (push && !pop) begin
                    state_nxt = FULL;
                    ld_skid   = 1'b1;
                end else if (push && pop) begin
                    ld_main   = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
                FULL: if (pop) begin
                    state_nxt = ONE;
                    ld_main   = 1'b1;
                    sel_skid  = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if (ld_main) main_q <= sel_skid ? skid_q : in_data;
                if (ld_skid) skid_q <= in_data;
            end
        end
    end else begin : g_pass
        assign out_valid = in_valid;
        assign in_ready  = out_ready;
        assign out_data  = in_data;
    end
endmodule

module axi_req_cut
    import ariane_axi::*;
#(
    parameter bit CUT_AW = 1'b1,
    parameter bit CUT_W  = 1'b1,
    parameter bit CUT_B  = 1'b1,
    parameter bit CUT_AR = 1'b1,
    parameter bit CUT_R  = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    axi_req_cut_if.slave  slv,
    axi_req_cut_if.master mst
`ifdef AXI_REQ_CUT_PERF_EN
   ,output logic [31:0]   aw_cnt_o,
    output logic [31:0]   ar_cnt_o
`endif
);
    aw_chan_t aw_data;
    w_chan_t  w_data;
    b_chan_t  b_data;
    ar_chan_t ar_data;
    r_chan_t  r_data;
    logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic ar_valid, ar_ready, r_valid, r_ready;

    axi_req_cut_slice #(.CUT(CUT_AW), .T(aw_chan_t)) u_aw (
        .clk(clk_i), .rst_n(rst_ni),
        .in_valid(slv.req.aw_valid), .in_ready(aw_ready), .in_data(slv.req.aw),
        .out_valid(aw_valid), .out_ready(mst.resp.aw_ready), .out_data(aw_data)
    );

    axi_req_cut_slice #(.CUT(CUT_W), .T(w_chan_t)) u_w (
        .clk(clk_i), .rst_n(rst_ni),
        .in_valid(slv.req.w_valid), .in_ready(w_ready), .in_data(slv.req.w),
        .out_valid(w_valid), .out_ready(mst.resp.w_ready), .out_data(w_data)
    );

    axi_req_cut_slice #(.CUT(CUT_AR), .T(ar_chan_t)) u_ar (
        .clk(clk_i), .rst_n(rst_ni),
        .in_valid(slv.req.ar_valid), .in_ready(ar_ready), .in_data(slv.req.ar),
        .out_valid(ar_valid), .out_ready(mst.resp.ar_ready), .out_data(ar_data)
    );

    axi_req_cut_slice #(.CUT(CUT_B), .T(b_chan_t)) u_b (
        .clk(clk_i), .rst_n(rst_ni),
        .in_valid(mst.resp.b_valid), .in_ready(b_ready), .in_data(mst.resp.b),
        .out_valid(b_valid), .out_ready(slv.req.b_ready), .out_data(b_data)
    );

    axi_req_cut_slice #(.CUT(CUT_R), .T(r_chan_t)) u_r (
        .clk(clk_i), .rst_n(rst_ni),
        .in_valid(mst.resp.r_valid), .in_ready(r_ready), .in_data(mst.resp.r),
        .out_valid(r_valid), .out_ready(slv.req.r_ready), .out_data(r_data)
    );

    always_comb begin
        mst.req          = '0;
        mst.req.aw       = aw_data;
        mst.req.aw_valid = aw_valid;
        mst.req.w        = w_data;
        mst.req.w_valid  = w_valid;
        mst.req.b_ready  = b_ready;
        mst.req.ar       = ar_data;
        mst.req.ar_valid = ar_valid;
        mst.req.r_ready  = r_ready;
    end

    always_comb begin
        slv.resp          = '0;
        slv.resp.aw_ready = aw_ready;
        slv.resp.w_ready  = w_ready;
        slv.resp.ar_ready = ar_ready;
        slv.resp.b_valid  = b_valid;
        slv.resp.b        = b_data;
        slv.resp.r_valid  = r_valid;
        slv.resp.r        = r_data;
    end

`ifdef AXI_REQ_CUT_PERF_EN
    logic [31:0] aw_cnt_q, ar_cnt_q;

    // Counts core-side acceptances, saturating at all-ones
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_cnt_q <= '0;
            ar_cnt_q <= '0;
        end else begin
            if (slv.req.aw_valid && aw_ready && aw_cnt_q != '1)
                aw_cnt_q <= aw_cnt_q + 32'd1;
            if (slv.req.ar_valid && ar_ready && ar_cnt_q != '1)
                ar_cnt_q <= ar_cnt_q + 32'd1;
        end
    end

    assign aw_cnt_o = aw_cnt_q;
    assign ar_cnt_o = ar_cnt_q;
`endif
endmodule

// File: tb/tb_axi_req_cut.sv
// Directed bench for axi_req_cut: reset, streaming, back-pressure,
// push/pop in ONE, mid-op reset and (with AXI_REQ_CUT_PERF_EN) counters.
module tb_axi_req_cut;
    logic clk;
    logic rst_ni;
    int   total;
    int   passed;

    axi_req_cut_if slv ();
    axi_req_cut_if mst ();

`ifdef AXI_REQ_CUT_PERF_EN
    logic [31:0] aw_cnt, ar_cnt;
`endif

    axi_req_cut dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .slv(slv),
        .mst(mst)
`ifdef AXI_REQ_CUT_PERF_EN
       ,.aw_cnt_o(aw_cnt),
        .ar_cnt_o(ar_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    localparam logic [63:0] D0 = 64'h0000_1111_2222_3333;
    localparam logic [63:0] D1 = 64'h4444_5555_6666_7777;
    localparam logic [63:0] D2 = 64'h8888_9999_AAAA_BBBB;

    initial begin
        total    = 0;
        passed   = 0;
        rst_ni   = 1'b0;
        slv.req  = '0;
        mst.resp = '0;

        slv.req.ar_valid = 1'b1;
        slv.req.ar.id    = 4'h1;
        slv.req.ar.addr  = 64'h8000_0000;
        @(negedge clk);
        chk("rst_mst_ar_valid", mst.req.ar_valid, 0);
        chk("rst_slv_ar_ready", slv.resp.ar_ready, 1);
        chk("rst_other_valids", {mst.req.aw_valid, mst.req.w_valid,
            slv.resp.b_valid, slv.resp.r_valid}, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("ar_not_before_hs", mst.req.ar_valid, 0);
        @(negedge clk);
        chk("ar_after_hs", {mst.req.ar_valid, mst.req.ar.id,
            mst.req.ar.addr}, {1'b1, 4'h1, 64'h8000_0000});
        slv.req.ar_valid  = 1'b0;
        mst.resp.ar_ready = 1'b1;
        @(negedge clk);
        chk("ar_drained", mst.req.ar_valid, 0);

        slv.req.r_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mst.resp.r_valid = 1'b1;
            mst.resp.r.id    = 4'h6;
            mst.resp.r.data  = 64'hA5A5_0000_0000_0000 | 64'(i);
            mst.resp.r.last  = (i == 7);
            @(negedge clk);
            chk($sformatf("r_beat%0d", i),
                {mst.req.r_ready, slv.resp.r_valid, slv.resp.r.last,
                 slv.resp.r.id, slv.resp.r.data},
                {1'b1, 1'b1, (i == 7), 4'h6,
                 64'hA5A5_0000_0000_0000 | 64'(i)});
        end
        mst.resp.r_valid = 1'b0;
        @(negedge clk);
        chk("r_drained", slv.resp.r_valid, 0);

        mst.resp.w_ready = 1'b0;
        slv.req.w_valid  = 1'b1;
        slv.req.w.data   = D0;
        slv.req.w.last   = 1'b0;
        @(negedge clk);
        chk("w_one_ready", slv.resp.w_ready, 1);
        slv.req.w.data = D1;
        @(negedge clk);
        chk("w_full_ready", slv.resp.w_ready, 0);
        chk("w_hold_d0", {mst.req.w_valid, mst.req.w.data}, {1'b1, D0});
        slv.req.w.data = D2;
        slv.req.w.last = 1'b1;
        @(negedge clk);
        chk("w_stall_ready", slv.resp.w_ready, 0);
        chk("w_stall_d0", {mst.req.w_valid, mst.req.w.data}, {1'b1, D0});
        mst.resp.w_ready = 1'b1;
        @(negedge clk);
        chk("w_out_d1", {mst.req.w_valid, mst.req.w.last, mst.req.w.data},
            {1'b1, 1'b0, D1});
        chk("w_ready_reopen", slv.resp.w_ready, 1);
        @(negedge clk);
        chk("w_out_d2", {mst.req.w_valid, mst.req.w.last, mst.req.w.data},
            {1'b1, 1'b1, D2});
        slv.req.w_valid = 1'b0;
        @(negedge clk);
        chk("w_drained", mst.req.w_valid, 0);

        slv.req.b_ready  = 1'b0;
        mst.resp.b_valid = 1'b1;
        mst.resp.b.id    = 4'h3;
        @(negedge clk);
        chk("b_hold3", {slv.resp.b_valid, slv.resp.b.id}, {1'b1, 4'h3});
        mst.resp.b.id   = 4'h5;
        slv.req.b_ready = 1'b1;
        @(negedge clk);
        chk("b_id5", {slv.resp.b_valid, slv.resp.b.id}, {1'b1, 4'h5});
        chk("b_state_one", mst.req.b_ready, 1);
        mst.resp.b_valid = 1'b0;
        @(negedge clk);
        chk("b_drained", slv.resp.b_valid, 0);

        mst.resp.aw_ready = 1'b0;
        slv.req.aw_valid  = 1'b1;
        slv.req.aw.id     = 4'h1;
        slv.req.aw.addr   = 64'h1000;
        @(negedge clk);
        slv.req.aw.addr = 64'h2000;
        @(negedge clk);
        chk("aw_full", {slv.resp.aw_ready, mst.req.aw_valid}, 2'b01);
        slv.req.aw_valid = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("aw_rst_valid", mst.req.aw_valid, 0);
        chk("aw_rst_ready", slv.resp.aw_ready, 1);
        @(negedge clk);
        rst_ni = 1'b1;
        mst.resp.aw_ready = 1'b1;
        @(negedge clk);
        chk("aw_no_stale", mst.req.aw_valid, 0);
        slv.req.aw_valid = 1'b1;
        slv.req.aw.id    = 4'h2;
        slv.req.aw.addr  = 64'h3000;
        @(negedge clk);
        chk("aw_new", {mst.req.aw_valid, mst.req.aw.id, mst.req.aw.addr},
            {1'b1, 4'h2, 64'h3000});
        slv.req.aw_valid = 1'b0;
        @(negedge clk);
        chk("aw_drained", mst.req.aw_valid, 0);

`ifdef AXI_REQ_CUT_PERF_EN
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        chk("cnt_reset", {aw_cnt, ar_cnt}, 0);
        mst.resp.ar_ready = 1'b1;
        slv.req.aw_valid  = 1'b1;
        slv.req.ar_valid  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        slv.req.ar_valid = 1'b0;
        @(negedge clk);
        slv.req.aw_valid = 1'b0;
        @(negedge clk);
        chk("cnt_aw3_ar2", {aw_cnt, ar_cnt}, {32'd3, 32'd2});
        force dut.aw_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.aw_cnt_q;
        slv.req.aw_valid = 1'b1;
        @(negedge clk);
        slv.req.aw_valid = 1'b0;
        chk("cnt_saturate", aw_cnt, 32'hFFFF_FFFF);
        chk("cnt_ar_steady", ar_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
